// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch-redirect logic and the PC sequencer.
interface pc_sequencer_if;
   logic        STALL;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic        JUMP;
   logic        CALL;
   logic        RET;
   logic [31:0] JUMP_TARGET;
   logic [31:0] PC_OUT;
   logic [31:0] PC_PLUS4;
   logic        FETCH_VALID;
   logic        ALIGN_ERR;
   logic        RAS_EMPTY;
   logic        RAS_OVF;
   logic        RAS_UNF;

   modport master (
      output STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, CALL, RET, JUMP_TARGET,
      input  PC_OUT, PC_PLUS4, FETCH_VALID, ALIGN_ERR, RAS_EMPTY, RAS_OVF, RAS_UNF
   );

   modport slave (
      input  STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, CALL, RET, JUMP_TARGET,
      output PC_OUT, PC_PLUS4, FETCH_VALID, ALIGN_ERR, RAS_EMPTY, RAS_OVF, RAS_UNF
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with prioritised next-PC selection and a circular
// return-address stack for call/return.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   pc_sequencer_if.slave   bus
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {BOOT, RUN} state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic              align_err_q, align_err_d;
   logic              ras_ovf_q, ras_ovf_d;
   logic              ras_unf_q, ras_unf_d;
   logic [PTR_W-1:0]  ras_top_q, ras_top_d;
   logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
   logic [31:0]       ras_mem_q [RAS_DEPTH];
   logic [31:0]       ras_mem_d [RAS_DEPTH];

   logic [31:0]       pc_plus4;
   logic [PTR_W-1:0]  push_ptr;

   assign pc_plus4 = pc_q + 32'd4;
   // Top points at the newest entry; a push when full lands on the oldest.
   assign push_ptr = ras_top_q + PTR_W'(1);

   // Next-state, next-PC and RAS update selection
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_valid_d = fetch_valid_q;
      align_err_d   = 1'b0;
      ras_ovf_d     = ras_ovf_q;
      ras_unf_d     = ras_unf_q;
      ras_top_d     = ras_top_q;
      ras_cnt_d     = ras_cnt_q;
      ras_mem_d     = ras_mem_q;

      unique case (state_q)
         BOOT: begin
            state_d       = RUN;
            fetch_valid_d = 1'b1;
         end
         RUN: begin
            if (!bus.STALL) begin
               if (bus.RET) begin
                  if (ras_cnt_q != '0) begin
                     pc_d      = ras_mem_q[ras_top_q];
                     ras_top_d = ras_top_q - PTR_W'(1);
                     ras_cnt_d = ras_cnt_q - CNT_W'(1);
                  end else begin
                     ras_unf_d = 1'b1;
                     pc_d      = pc_plus4;
                  end
               end else if (bus.CALL) begin
                  ras_mem_d[push_ptr] = pc_plus4;
                  ras_top_d           = push_ptr;
                  if (ras_cnt_q == CNT_W'(RAS_DEPTH)) begin
                     ras_ovf_d = 1'b1;
                  end else begin
                     ras_cnt_d = ras_cnt_q + CNT_W'(1);
                  end
                  pc_d        = {bus.JUMP_TARGET[31:2], 2'b00};
                  align_err_d = |bus.JUMP_TARGET[1:0];
               end else if (bus.JUMP) begin
                  pc_d        = {bus.JUMP_TARGET[31:2], 2'b00};
                  align_err_d = |bus.JUMP_TARGET[1:0];
               end else if (bus.BRANCH_TAKEN) begin
                  pc_d        = {bus.BRANCH_TARGET[31:2], 2'b00};
                  align_err_d = |bus.BRANCH_TARGET[1:0];
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // State, PC and RAS registers with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         align_err_q   <= 1'b0;
         ras_ovf_q     <= 1'b0;
         ras_unf_q     <= 1'b0;
         ras_top_q     <= '0;
         ras_cnt_q     <= '0;
         for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            ras_mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         align_err_q   <= align_err_d;
         ras_ovf_q     <= ras_ovf_d;
         ras_unf_q     <= ras_unf_d;
         ras_top_q     <= ras_top_d;
         ras_cnt_q     <= ras_cnt_d;
         ras_mem_q     <= ras_mem_d;
      end
   end

   assign bus.PC_OUT      = pc_q;
   assign bus.PC_PLUS4    = pc_plus4;
   assign bus.FETCH_VALID = fetch_valid_q;
   assign bus.ALIGN_ERR   = align_err_q;
   assign bus.RAS_EMPTY   = (ras_cnt_q == '0);
   assign bus.RAS_OVF     = ras_ovf_q;
   assign bus.RAS_UNF     = ras_unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer.
module tb_pc_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pc_sequencer_if bus ();

   pc_sequencer #(
      .RESET_PC  (32'h0000_0000),
      .RAS_DEPTH (4)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] bt;
      logic        jmp;
      logic        call;
      logic        ret;
      logic [31:0] jt;
      logic [31:0] e_pc;
      logic        e_al;
      logic        e_em;
      logic        e_ov;
      logic        e_un;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic stall, logic br, logic [31:0] bt, logic jmp,
                               logic call, logic ret, logic [31:0] jt,
                               logic [31:0] e_pc, logic e_al, logic e_em,
                               logic e_ov, logic e_un);
      vec_t v;
      v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.call = call;
      v.ret = ret; v.jt = jt; v.e_pc = e_pc; v.e_al = e_al; v.e_em = e_em;
      v.e_ov = e_ov; v.e_un = e_un;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic stall, input logic br, input logic [31:0] bt,
                        input logic jmp, input logic call, input logic ret,
                        input logic [31:0] jt);
      bus.STALL = stall; bus.BRANCH_TAKEN = br; bus.BRANCH_TARGET = bt;
      bus.JUMP = jmp; bus.CALL = call; bus.RET = ret; bus.JUMP_TARGET = jt;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;

      //         stall br bt            jmp call ret jt             e_pc          al em ov un
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0004, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0008, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h10,       32'h0000_0010, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h80,       1, 0, 0, 32'h40,       32'h0000_0040, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 32'h83,       0, 0, 0, 32'h0,        32'h0000_0080, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0084, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h100,      32'h0000_0100, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h200,      32'h0000_0200, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h300,      32'h0000_0300, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_0204, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_0104, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h400,      32'h0000_0400, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h600,      32'h0000_0108, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h700,      32'h0000_0108, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h700,      32'h0000_0108, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h700,      32'h0000_0108, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h700,      32'h0000_0700, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_010C, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h1001,     32'h0000_1000, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 32'h2222,     32'h0000_1000, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h2000,     32'h0000_2000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h3000,     32'h0000_3000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h4000,     32'h0000_4000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h5000,     32'h0000_5000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'h6000,     32'h0000_6000, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_5004, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_4004, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_3004, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_2004, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0,        32'h0000_2008, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0000, 0, 1, 1, 1));

      // Reset and boot
      drive(0, 0, '0, 0, 0, 0, '0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc", bus.PC_OUT, 32'h0);
      check("rst_fv", 32'(bus.FETCH_VALID), 32'h0);
      check("rst_empty", 32'(bus.RAS_EMPTY), 32'h1);
      check("rst_al", 32'(bus.ALIGN_ERR), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("boot_pc", bus.PC_OUT, 32'h0);
      check("boot_fv", 32'(bus.FETCH_VALID), 32'h1);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].call,
               vecs[i].ret, vecs[i].jt);
         @(posedge clk); #1;
         check($sformatf("v%0d_pc", i), bus.PC_OUT, vecs[i].e_pc);
         check($sformatf("v%0d_pc4", i), bus.PC_PLUS4, vecs[i].e_pc + 32'd4);
         check($sformatf("v%0d_al", i), 32'(bus.ALIGN_ERR), 32'(vecs[i].e_al));
         check($sformatf("v%0d_empty", i), 32'(bus.RAS_EMPTY), 32'(vecs[i].e_em));
         check($sformatf("v%0d_ovf", i), 32'(bus.RAS_OVF), 32'(vecs[i].e_ov));
         check($sformatf("v%0d_unf", i), 32'(bus.RAS_UNF), 32'(vecs[i].e_un));
         check($sformatf("v%0d_fv", i), 32'(bus.FETCH_VALID), 32'h1);
      end

      // Push something, then drop reset mid-cycle with no clock edge
      @(negedge clk);
      drive(0, 0, '0, 0, 1, 0, 32'h0000_0A01);
      @(posedge clk); #1;
      check("pre_rst_pc", bus.PC_OUT, 32'h0000_0A00);
      check("pre_rst_al", 32'(bus.ALIGN_ERR), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_pc", bus.PC_OUT, 32'h0);
      check("async_fv", 32'(bus.FETCH_VALID), 32'h0);
      check("async_al", 32'(bus.ALIGN_ERR), 32'h0);
      check("async_empty", 32'(bus.RAS_EMPTY), 32'h1);
      check("async_ovf", 32'(bus.RAS_OVF), 32'h0);
      check("async_unf", 32'(bus.RAS_UNF), 32'h0);

      // Controls are ignored on the boot edge
      @(negedge clk);
      drive(0, 0, '0, 1, 0, 0, 32'h40);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("boot2_pc", bus.PC_OUT, 32'h0);
      check("boot2_fv", 32'(bus.FETCH_VALID), 32'h1);
      @(posedge clk); #1;
      check("run2_pc", bus.PC_OUT, 32'h40);

      // RAS was discarded by reset: a return underflows
      @(negedge clk);
      drive(0, 0, '0, 0, 0, 1, '0);
      @(posedge clk); #1;
      check("post_rst_ret_pc", bus.PC_OUT, 32'h44);
      check("post_rst_unf", 32'(bus.RAS_UNF), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter register and next-PC selector for the single-cycle CPU. It holds the current fetch address and produces PC+4 internally, modulo 2^32. Each cycle it picks the next PC from: sequential, branch, jump, call, or return. A 4-entry return-address stack (RAS) handles call/return. It closes the loop around the PC+4 path: it consumes the incremented value and supplies the instruction-memory address.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
RAS_DEPTH, 4, number of return-address stack entries; must be a power of 2, minimum 2.

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
STALL  in  1  hold PC and RAS this cycle
BRANCH_TAKEN  in  1  redirect to BRANCH_TARGET
BRANCH_TARGET  in  32  branch destination
JUMP  in  1  redirect to JUMP_TARGET
CALL  in  1  push PC+4 onto RAS, redirect to JUMP_TARGET
RET  in  1  pop RAS, redirect to popped address
JUMP_TARGET  in  32  jump/call destination
PC_OUT  out  32  current fetch address (registered)
PC_PLUS4  out  32  PC_OUT+4, combinational, wraps modulo 2^32
FETCH_VALID  out  1  PC_OUT is a valid fetch address
ALIGN_ERR  out  1  registered one-cycle pulse: selected target had bits [1:0] != 0
RAS_EMPTY  out  1  RAS count == 0
RAS_OVF  out  1  sticky: a push occurred with RAS full
RAS_UNF  out  1  sticky: RET occurred with RAS empty

Behaviour:
- Reset (async, RST_N=0):
  - PC_OUT=RESET_PC, FETCH_VALID=0, ALIGN_ERR=0.
  - RAS count=0, RAS_EMPTY=1, RAS_OVF=0, RAS_UNF=0.
  - State=BOOT.
- States:
  - BOOT: first rising edge after RST_N release -> RUN, FETCH_VALID<=1, PC_OUT unchanged (RESET_PC is fetched first). All control inputs are ignored in BOOT.
  - RUN: normal update on every rising edge.
- Asserting RST_N mid-operation returns immediately to reset values and BOOT. RAS contents are discarded.
- RUN, STALL=1: PC_OUT, RAS and sticky flags hold; ALIGN_ERR<=0; FETCH_VALID stays 1. All redirect inputs are ignored.
- RUN, STALL=0: next PC is chosen by fixed priority:
  - RET: if RAS non-empty, pop top, next=popped value. If RAS empty, RAS_UNF<=1 and next=PC_PLUS4.
  - CALL: push PC_PLUS4, next=JUMP_TARGET.
  - JUMP: next=JUMP_TARGET.
  - BRANCH_TAKEN: next=BRANCH_TARGET.
  - Otherwise: next=PC_PLUS4.
- Only the highest-priority asserted input takes effect. Lower-priority inputs in the same cycle are ignored. For example, RET+CALL together means pop only, no push.
- Alignment:
  - The selected target is loaded with bits [1:0] forced to 0.
  - If the raw target had nonzero bits [1:0], ALIGN_ERR<=1 for one cycle.
  - Sequential and popped values are always aligned.
- RAS:
  - Circular buffer with top pointer and count in 0..RAS_DEPTH.
  - Push when full: overwrite the oldest entry, count stays RAS_DEPTH, RAS_OVF<=1.
  - Pop: count-1, pointer moves back.
  - Push and pop take effect at the same edge as the PC update.
- Wrap: PC_OUT=32'hFFFF_FFFC gives PC_PLUS4=0; the sequential next PC is 0 with no flag.
- Latency: a redirect asserted in cycle N appears on PC_OUT after the rising edge ending cycle N (one-cycle latency).

Test Plan:
- Reset/boot: hold RST_N=0, release, run 3 edges with no controls -> PC_OUT 0, 0, 4, 8; FETCH_VALID 0 then 1 from the first edge.
- Priority/branch: PC=0x10, BRANCH_TAKEN=1 with BRANCH_TARGET=0x80 and JUMP=1 with JUMP_TARGET=0x40 -> next PC 0x40. Then BRANCH alone to 0x83 -> PC 0x80, ALIGN_ERR pulse for one cycle.
- Call/return nesting: CALL at PC 0x100 to 0x200, CALL at 0x200 to 0x300, then RET, RET -> PC sequence 0x200, 0x300, 0x204, 0x104; RAS_EMPTY=1 at the end; no OVF/UNF.
- RAS overflow/underflow: 5 CALLs (RAS_DEPTH=4) -> RAS_OVF=1; 4 RETs return the 4 newest addresses; 5th RET -> RAS_UNF=1, PC = previous PC+4.
- Stall: STALL=1 for 3 cycles with CALL=1 -> PC and RAS count unchanged. Release STALL with CALL held -> exactly one push.
- Wrap and async reset: force PC to 0xFFFF_FFFC -> next PC 0. Drop RST_N mid-cycle -> PC_OUT=RESET_PC immediately, FETCH_VALID=0, RAS flags cleared.
